ram_loader: RTL and testbench
=============================

# ram_loader

Boot-time loader that sits directly upstream of `ram16k`. It accepts a framed byte stream (length, data words, checksum) over a valid/ready handshake and assembles big-endian 16-bit words. Each word is written into consecutive RAM addresses starting at 0, and the frame checksum is verified. While the loader is busy it owns the RAM port; the CPU is held off by `busy`.

## Interface
- `ADDR_W`, 14: RAM address width; capacity is 2**ADDR_W words.
- `DATA_W`, 16: RAM word width; fixed at 2 bytes.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: single-cycle request to begin a frame; honoured only in IDLE or DONE.
- `byte_in`  in  8: stream byte.
- `byte_valid`  in  1: `byte_in` is valid.
- `byte_ready`  out  1: loader accepts a byte this cycle; transfer occurs when `byte_valid && byte_ready`.
- `busy`  out  1: high from accepted `start` until DONE.
- `done`  out  1: level, high in DONE until the next `start` or `reset`.
- `error`  out  1: valid while `done`; set on length overflow or checksum mismatch.
- `words_written`  out  ADDR_W+1: count of RAM writes in the current frame.
- `ram_address`  out  ADDR_W: RAM address.
- `ram_in_value`  out  DATA_W: RAM write data.
- `ram_load`  out  1: RAM mode pin. `ram16k` writes on every edge where this pin is low, so the loader drives it low only in WRITE and high at all other times.

## Operation
- Frame format: LEN_HI, LEN_LO, then N×(D_HI, D_LO), then SUM_HI, SUM_LO. All fields are big-endian.
- SUM = sum of the N data words, modulo 2^16. The length field is not included.
- States and transitions:
  - IDLE: on `start` → LEN_HI. Clears `words_written`, the checksum accumulator and `error`; sets `ram_address` = 0.
  - LEN_HI, then LEN_LO: each takes one accepted byte. After LEN_LO:
    - N = 0 → SUM_HI.
    - N > 2**ADDR_W → DONE with `error` = 1 and no writes.
    - otherwise → DATA_HI.
  - DATA_HI, then DATA_LO: the two bytes form a word, latched into `ram_in_value` → WRITE.
  - WRITE: exactly one cycle with `ram_load` = 0. Adds the word to the checksum and increments `words_written`.
    - If the written count equals N → SUM_HI.
    - Otherwise `ram_address` increments → DATA_HI.
  - SUM_HI, then SUM_LO: compare the received sum against the accumulator; `error` = mismatch → DONE.
  - DONE: `busy` = 0, `done` = 1; `start` → LEN_HI with the same clearing as from IDLE.
- `start` is ignored in all other states.
- `byte_ready` = 1 only in LEN_*, DATA_*, SUM_* states.
- Width rules:
  - N = 2**ADDR_W is legal and fills the whole RAM.
  - `ram_address` never wraps; the last write goes to 2**ADDR_W−1.
- No bytes are consumed after SUM_LO until the next `start`.
- RAM contents are never cleared; words already written persist after an error or reset.

## Timing
- Reset values:
  - state IDLE; `byte_ready` 0, `busy` 0, `done` 0, `error` 0.
  - `ram_load` 1, `ram_address` 0, `ram_in_value` 0, `words_written` 0.
- Reset mid-frame: on the next edge the loader returns to IDLE and `ram_load` = 1, including when reset arrives during WRITE. The in-flight write completes only if it was already on that edge.
- `busy` rises on the edge after `start`.
- Word latency: the write edge is 1 cycle after the edge that accepted D_LO.
- Peak throughput: 2 bytes per 3 cycles (`byte_ready` is low in WRITE).
- `ram_address` and `ram_in_value` are stable for the whole WRITE cycle.
- `done` and `error` rise together on the edge that accepts SUM_LO, or LEN_LO when the length overflows.
- `byte_valid` low stalls the loader in its current state indefinitely.

## Structure
- Package `ram_loader_pkg`: state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, SUM_HI, SUM_LO, DONE) and the `ADDR_W`/`DATA_W` defaults.
- One natural sub-module, `byte_pair_assembler`: holds the high byte, emits a DATA_W word plus a `word_valid` pulse on the low byte. It is shared by the length, data and sum fields.
- The FSM, address counter and checksum accumulator stay in `ram_loader`.

## Test plan
- Frame N=3, words 0x1234, 0xABCD, 0x0001, SUM 0xBE02, `byte_valid` held high → RAM[0..2] hold those words; `done` = 1, `error` = 0, `words_written` = 3; exactly 3 cycles with `ram_load` = 0.
- Same frame with SUM 0xBE03 → same RAM contents, `done` = 1, `error` = 1.
- N = 0, SUM 0x0000 → no writes, `done` = 1, `error` = 0. LEN = 0x4001 → `error` = 1 immediately after LEN_LO, zero writes, no further bytes accepted.
- Random `byte_valid` gaps on the N=3 frame → identical result; `ram_load` stays high during stalls.
- Assert `reset` during the second WRITE → next cycle IDLE, `ram_load` = 1, all outputs at reset values; RAM[0] = 0x1234. A new `start` plus a full frame then succeeds.
- N = 16384 incrementing words → last write at address 0x3FFF; `words_written` = 16384; `error` = 0 with the correct sum.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and default widths for the boot-time RAM loader.
package ram_loader_pkg;

  localparam int LOADER_ADDR_W = 14;
  localparam int LOADER_DATA_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    SUM_HI,
    SUM_LO,
    DONE
  } state_t;

endpackage

// File: rtl/ram_loader_byte_pair_assembler.sv
// Joins a held high byte with the current low byte into one big-endian word.
module byte_pair_assembler
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              take_hi,
  input  logic              take_lo,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  logic [7:0] hi_q;
  logic [7:0] hi_d;

  always_comb begin
    hi_d = hi_q;
    if (take_hi) hi_d = byte_in;
  end

  always_ff @(posedge clk) begin
    if (reset) hi_q <= '0;
    else       hi_q <= hi_d;
  end

  // The word is combinational so the FSM can act on it in the same cycle.
  assign word       = DATA_W'({hi_q, byte_in});
  assign word_valid = take_lo;

endmodule

// File: rtl/ram_loader.sv
// Framed byte-stream loader: LEN, N data words, SUM; writes words to RAM from
// address 0 and verifies the 16-bit additive checksum.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in_value,
  output logic              ram_load
);

  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              error_q, error_d;

  logic              fire;
  logic              take_hi;
  logic              take_lo;
  logic [DATA_W-1:0] asm_word;
  logic              asm_valid;

  assign byte_ready = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO};
  assign fire       = byte_valid && byte_ready;
  assign take_hi    = fire && (state_q inside {LEN_HI, DATA_HI, SUM_HI});
  assign take_lo    = fire && (state_q inside {LEN_LO, DATA_LO, SUM_LO});

  byte_pair_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .take_hi    (take_hi),
    .take_lo    (take_lo),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    len_d   = len_q;
    sum_d   = sum_q;
    error_d = error_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LEN_HI;
          addr_d  = '0;
          count_d = '0;
          sum_d   = '0;
          error_d = 1'b0;
        end
      end
      LEN_HI:  if (fire) state_d = LEN_LO;
      LEN_LO: begin
        if (asm_valid) begin
          len_d = (ADDR_W+1)'(asm_word);
          if (asm_word == '0) begin
            state_d = SUM_HI;
          end else if (32'(asm_word) > MAX_LEN) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: if (fire) state_d = DATA_LO;
      DATA_LO: begin
        if (asm_valid) begin
          data_d  = asm_word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        sum_d   = sum_q + data_q;
        count_d = count_q + 1'b1;
        // Address only advances when another word follows, so it never wraps.
        if (count_d == len_q) begin
          state_d = SUM_HI;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = DATA_HI;
        end
      end
      SUM_HI:  if (fire) state_d = SUM_LO;
      SUM_LO: begin
        if (asm_valid) begin
          error_d = (asm_word != sum_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      error_q <= error_d;
    end
  end

  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign words_written = count_q;
  assign ram_address   = addr_q;
  assign ram_in_value  = data_q;
  assign ram_load      = (state_q != WRITE);

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected RAM writes and frame results are
// queued by the stimulus and consumed by a monitor watching the DUT outputs.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [14:0] words_written;
  logic [13:0] ram_address;
  logic [15:0] ram_in_value;
  logic        ram_load;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  logic [15:0] mem [0:16383];
  logic [15:0] fw  [0:16383];
  logic [31:0] wq[$];
  logic [31:0] dq[$];
  logic        done_prev = 1'b0;

  ram_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written),
    .ram_address   (ram_address),
    .ram_in_value  (ram_in_value),
    .ram_load      (ram_load)
  );

  always #5 clk = ~clk;

  // ram16k behaviour: write on every edge with the mode pin low
  always @(posedge clk) begin
    if (ram_load === 1'b0) mem[ram_address] <= ram_in_value;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (ram_load === 1'b0) begin
      wr_seen++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h expected none", ram_address, ram_in_value);
      end else begin
        e = wq.pop_front();
        chk("write_addr", 32'(ram_address), 32'(e[29:16]));
        chk("write_data", 32'(ram_in_value), 32'(e[15:0]));
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual error=%b words=%0d expected none", error, words_written);
      end else begin
        e = dq.pop_front();
        chk("done_error", 32'(error), 32'(e[16]));
        chk("done_words", 32'(words_written), 32'(e[15:0]));
      end
    end
    done_prev = done;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int gap;
    int n;
    gap = gaps ? int'($urandom_range(0, 3)) : 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 expected=1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_frame(input int n, input logic [15:0] sum, input bit exp_err, input bit gaps);
    int wr0;
    for (int i = 0; i < n; i++) wq.push_back({2'b00, 14'(i), fw[i]});
    dq.push_back({15'd0, exp_err, 16'(n)});
    wr0 = wr_seen;
    do_start();
    send_byte(8'(n >> 8), gaps);
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(fw[i][15:8], gaps);
      send_byte(fw[i][7:0], gaps);
      if (i < 4) chk("write_latency", 32'(ram_load), 32'd0);
    end
    send_byte(sum[15:8], gaps);
    send_byte(sum[7:0], gaps);
    #1;
    chk("done_level", 32'(done), 32'd1);
    chk("busy_low", 32'(busy), 32'd0);
    chk("error_level", 32'(error), 32'(exp_err));
    chk("write_count", 32'(wr_seen - wr0), 32'(n));
    chk("queues_drained", 32'(wq.size() + dq.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_ram_load"}, 32'(ram_load), 32'd1);
    chk({tag, "_addr"}, 32'(ram_address), 32'd0);
    chk({tag, "_data"}, 32'(ram_in_value), 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // N=3, good checksum
    fw[0] = 16'h1234; fw[1] = 16'hABCD; fw[2] = 16'h0001;
    send_frame(3, 16'hBE02, 1'b0, 1'b0);
    chk("mem0", 32'(mem[0]), 32'h1234);
    chk("mem1", 32'(mem[1]), 32'hABCD);
    chk("mem2", 32'(mem[2]), 32'h0001);

    // same frame, bad checksum
    send_frame(3, 16'hBE03, 1'b1, 1'b0);
    chk("bad_sum_mem1", 32'(mem[1]), 32'hABCD);

    // empty frame
    send_frame(0, 16'h0000, 1'b0, 1'b0);

    // length overflow: done after LEN_LO, nothing further accepted
    dq.push_back({15'd0, 1'b1, 16'd0});
    do_start();
    send_byte(8'h40, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_error", 32'(error), 32'd1);
    byte_valid = 1'b1;
    byte_in = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ovf_no_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    chk("ovf_words", 32'(words_written), 32'd0);

    // random valid gaps
    send_frame(3, 16'hBE02, 1'b0, 1'b1);
    chk("gap_mem2", 32'(mem[2]), 32'h0001);

    // reset during the second WRITE
    for (int i = 0; i < 3; i++) mem[i] = 16'h0000;
    wq.push_back({2'b00, 14'd0, 16'h1234});
    wq.push_back({2'b00, 14'd1, 16'hABCD});
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    chk("second_write_cycle", 32'(ram_load), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midreset");
    chk("midreset_mem0", 32'(mem[0]), 32'h1234);
    chk("midreset_queue", 32'(wq.size()), 32'd0);
    @(negedge clk);
    send_frame(3, 16'hBE02, 1'b0, 1'b0);
    chk("after_reset_mem2", 32'(mem[2]), 32'h0001);

    // full-capacity frame of incrementing words
    for (int i = 0; i < 16384; i++) fw[i] = 16'(i);
    send_frame(16384, 16'hE000, 1'b0, 1'b0);
    chk("full_words", 32'(words_written), 32'd16384);
    chk("full_last_addr", 32'(ram_address), 32'h3FFF);
    chk("full_mem_last", 32'(mem[16383]), 32'h3FFF);
    chk("full_mem_first", 32'(mem[0]), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
